// File: rtl/abs_diff_sad_if.sv
// rtl/abs_diff_sad_if.sv - sample input and block-result output handshake bundle
interface abs_diff_sad_if #(
  parameter int W = 4,
  parameter int N = 8
);
  localparam int OW = W + $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          approx_en;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sad;
  logic [W-1:0]  out_max;

  modport master (
    output in_valid, in_a, in_b, approx_en, out_ready,
    input  in_ready, out_valid, out_sad, out_max
  );

  modport slave (
    input  in_valid, in_a, in_b, approx_en, out_ready,
    output in_ready, out_valid, out_sad, out_max
  );
endinterface

// File: rtl/abs_diff_sad.sv
// rtl/abs_diff_sad.sv - block sum and max of absolute differences with optional LSB truncation
module abs_diff_sad #(
  parameter int W     = 4,
  parameter int N     = 8,
  parameter int TRUNC = 0
) (
  input logic           clk,
  input logic           rst,
  abs_diff_sad_if.slave bus
);
  localparam int OW = W + $clog2(N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  KEEP_MASK = {W{1'b1}} << TRUNC;
  localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic [OW-1:0] sum;
  logic [W-1:0]  max_d;

  logic [W-1:0]  d_exact;
  logic [W-1:0]  d;
  logic [OW-1:0] sum_next;
  logic [W-1:0]  max_next;
  logic          last;
  logic          accept;
  logic          ready;

  always_comb begin
    d_exact = (bus.in_a >= bus.in_b) ? (bus.in_a - bus.in_b) : (bus.in_b - bus.in_a);
    d       = bus.approx_en ? (d_exact & KEEP_MASK) : d_exact;
  end

  // OW is sized so N full-scale differences always fit; no saturation needed.
  assign sum_next = sum + OW'(d);
  assign max_next = (d > max_d) ? d : max_d;

  // Only the block-completing sample can collide with an unconsumed result.
  assign last   = (cnt == LAST_CNT);
  assign ready  = !(last && bus.out_valid && !bus.out_ready);
  assign accept = bus.in_valid && ready;

  assign bus.in_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sum   <= '0;
      max_d <= '0;
    end else if (accept) begin
      if (last) begin
        cnt   <= '0;
        sum   <= '0;
        max_d <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        sum   <= sum_next;
        max_d <= max_next;
      end
    end
  end

  // A completion on the consume edge reloads, so out_valid stays high without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sad   <= '0;
      bus.out_max   <= '0;
    end else if (accept && last) begin
      bus.out_valid <= 1'b1;
      bus.out_sad   <= sum_next;
      bus.out_max   <= max_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/abs_diff_sad.md
ABS_DIFF_SAD -- requirements
Module: abs_diff_sad

Interface
REQ-001 The block SHALL have parameter W, default 4, unsigned operand width (W >= 1).
REQ-002 The block SHALL have parameter N, default 8, number of samples per block (N >= 1).
REQ-003 The block SHALL have parameter TRUNC, default 0, count of |a-b| LSBs forced to zero in approximate mode (0 <= TRUNC <= W).
REQ-004 The block SHALL derive OW = W + clog2(N) (OW = W when N = 1) as the sum width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, which indicates that the sample is valid.
REQ-008 The block SHALL have port in_ready, output, 1, which indicates that the block can accept a sample.
REQ-009 The block SHALL have ports in_a and in_b, input, W, the unsigned operands.
REQ-010 The block SHALL have port approx_en, input, 1, which enables truncation for the sample presented with it.
REQ-011 The block SHALL have port out_valid, output, 1, which indicates that a block result is held.
REQ-012 The block SHALL have port out_ready, input, 1, through which the consumer accepts the result.
REQ-013 The block SHALL have port out_sad, output, OW, the sum of |a-b| over the block.
REQ-014 The block SHALL have port out_max, output, W, the maximum |a-b| within the block.

Function
REQ-015 A sample SHALL be accepted in any cycle where in_valid and in_ready are both 1; no other cycle SHALL alter the accumulators.
REQ-016 For each accepted sample, d = |in_a - in_b| SHALL be computed exactly in W bits; if approx_en = 1, bits [TRUNC-1:0] of d SHALL be zero.
REQ-017 The internal sum (OW bits), running max (W bits) and sample counter (0..N-1) SHALL update with d on each acceptance; the sum SHALL never overflow.
REQ-018 The counter SHALL wrap from N-1 to 0 on the acceptance that completes a block; on that edge sum and max SHALL clear, so the next sample starts a fresh block.
REQ-019 On a completing acceptance, the final sum and max (including that sample's d) SHALL load into out_sad and out_max, and out_valid SHALL be 1 the next cycle (latency 1 clock).
REQ-020 The result SHALL be consumed when out_valid and out_ready are both 1; out_valid SHALL drop the next cycle unless a new result loads on the same edge.
REQ-021 While out_valid = 1 and not consumed, out_sad and out_max SHALL hold stable.
REQ-022 in_ready SHALL be 1 except when counter = N-1, out_valid = 1 and out_ready = 0; in that case it SHALL be 0, so no result is ever overwritten or dropped.
REQ-023 Samples that do not complete a block SHALL be accepted regardless of the output state; accumulation of the next block SHALL continue while a previous result is pending.
REQ-024 If a result is consumed on the same edge as a new completion, the new result SHALL load and out_valid SHALL remain 1 without a gap.
REQ-025 in_ready SHALL depend only on state and out_ready; it SHALL NOT depend on in_valid.

Reset
REQ-026 When rst = 1 at an edge, the following SHALL be set: out_valid = 0, out_sad = 0, out_max = 0, counter = 0, sum = 0, max = 0.
REQ-027 Reset SHALL discard any partial block and any pending result; the first sample accepted after reset SHALL be sample 0 of a new block.
REQ-028 in_ready SHALL be 1 in the cycle after reset is released.

Verification (W=4, N=4, TRUNC=1, OW=6)
REQ-029 Exact block: a = 3,10,0,15 and b = 5,2,0,0 with approx_en = 0 -> one cycle after the 4th accept, out_valid = 1, out_sad = 25, out_max = 15.
REQ-030 Approximate block: the same operands with approx_en = 1 -> out_sad = 24 (diffs 2,8,0,14), out_max = 14.
REQ-031 Saturation range: a = 15, b = 0 for 4 samples -> out_sad = 60, out_max = 15, with no wrap.
REQ-032 Backpressure: hold out_ready = 0 after block 1 (sad 25) and stream block 2 -> 3 samples accepted, in_ready = 0 at counter = 3, out_sad stays 25; a 1-cycle out_ready pulse -> 4th sample accepted on that edge, block 2 result visible next cycle, out_valid continuous.
REQ-033 Reset mid-block: accept 2 samples (diffs 7,7), assert rst for 1 cycle, then feed diffs 1,1,1,1 -> out_sad = 4, out_max = 1.
REQ-034 Back-to-back with out_ready tied to 1: 8 consecutive samples -> out_valid high for exactly 1 cycle after the 4th accept and 1 cycle after the 8th accept, and in_ready is never 0.
